// File: rtl/countdown_display.sv
// Countdown display: converts a remaining-tick count into whole seconds
// and drives a two-digit multiplexed active-low seven-segment display.
module countdown_display #(
  parameter logic [31:0] TICKS_PER_SECOND = 32'd50000000,
  parameter logic [31:0] SAMPLE_TICKS     = 32'd500000,
  parameter logic [31:0] REFRESH_TICKS    = 32'd50000
) (
  input  logic        in_clock,
  input  logic        in_reset_n,
  input  logic [31:0] in_counter,
  input  logic        in_issue,
  output logic [6:0]  out_segments,
  output logic [1:0]  out_digit_enable,
  output logic [6:0]  out_seconds,
  output logic        out_busy
);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    BCD,
    LOAD
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t      state;
  state_t      state_next;

  logic [31:0] sample_cnt;
  logic        sample_tick;
  logic [31:0] refresh_cnt;
  logic        active;

  logic [31:0] dividend;
  logic [31:0] remainder;
  logic [4:0]  div_cnt;
  logic [2:0]  bcd_cnt;
  logic [6:0]  bin;
  logic [7:0]  bcd;
  logic [6:0]  seconds_q;
  logic [3:0]  tens;
  logic [3:0]  ones;

  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [31:0] quot_next;
  logic [6:0]  sat_next;
  logic [3:0]  ones_adj;
  logic [3:0]  tens_adj;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  assign sample_tick = (sample_cnt == SAMPLE_TICKS - 32'd1);

  // Restoring divide step: one quotient bit shifts into the dividend LSB.
  always_comb begin
    rem_shift = {remainder, dividend[31]};
    rem_diff  = rem_shift - {1'b0, TICKS_PER_SECOND};
    q_bit     = ~rem_diff[32];
    rem_next  = q_bit ? rem_diff[31:0] : rem_shift[31:0];
    quot_next = {dividend[30:0], q_bit};
    sat_next  = (quot_next > 32'd99) ? 7'd99 : quot_next[6:0];
  end

  // Shift-add-3 step: correct digits >= 5 before shifting.
  always_comb begin
    ones_adj = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    tens_adj = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
  end

  // Free-running sample counter; it never waits for the converter.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      sample_cnt <= '0;
    end else if (sample_tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + 32'd1;
    end
  end

  // State register.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; sample ticks outside IDLE are simply ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick) state_next = DIVIDE;
      DIVIDE:  if (div_cnt == 5'd31) state_next = BCD;
      BCD:     if (bcd_cnt == 3'd6) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic of the converter FSM.
  always_comb begin
    out_busy = (state != IDLE);
  end

  // Conversion datapath: capture, divide, saturate, BCD, publish.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      dividend    <= '0;
      remainder   <= '0;
      div_cnt     <= '0;
      bcd_cnt     <= '0;
      bin         <= '0;
      bcd         <= '0;
      seconds_q   <= '0;
      tens        <= '0;
      ones        <= '0;
      out_seconds <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_tick) begin
            dividend  <= in_counter;
            remainder <= '0;
            div_cnt   <= '0;
          end
        end
        DIVIDE: begin
          dividend  <= quot_next;
          remainder <= rem_next;
          div_cnt   <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) begin
            bin       <= sat_next;
            seconds_q <= sat_next;
            bcd       <= '0;
            bcd_cnt   <= '0;
          end
        end
        BCD: begin
          bcd     <= {tens_adj[2:0], ones_adj, bin[6]};
          bin     <= {bin[5:0], 1'b0};
          bcd_cnt <= bcd_cnt + 3'd1;
        end
        LOAD: begin
          out_seconds <= seconds_q;
          tens        <= bcd[7:4];
          ones        <= bcd[3:0];
        end
        default: ;
      endcase
    end
  end

  // Digit multiplex timer; ones digit is active first.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      refresh_cnt <= '0;
      active      <= 1'b0;
    end else if (refresh_cnt == REFRESH_TICKS - 32'd1) begin
      refresh_cnt <= '0;
      active      <= ~active;
    end else begin
      refresh_cnt <= refresh_cnt + 32'd1;
    end
  end

  // Registered display drive; tens is blanked for values below ten.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      out_segments     <= SEG_BLANK;
      out_digit_enable <= 2'b11;
    end else begin
      out_digit_enable <= active ? 2'b01 : 2'b10;
      if (in_issue) begin
        out_segments <= SEG_DASH;
      end else if (active) begin
        out_segments <= (tens == 4'd0) ? SEG_BLANK : seg_pattern(tens);
      end else begin
        out_segments <= seg_pattern(ones);
      end
    end
  end

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display with small timing parameters.
// A second instance with a short sample period exercises dropped ticks.
module tb_countdown_display;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S2    = 7'b0100100;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S4    = 7'b0011001;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S9    = 7'b0010000;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cnt;
  logic        issue;
  logic [6:0]  seg;
  logic [1:0]  en;
  logic [6:0]  sec;
  logic        busy;

  logic [31:0] cnt2;
  logic [6:0]  seg2;
  logic [1:0]  en2;
  logic [6:0]  sec2;
  logic        busy2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  countdown_display #(
    .TICKS_PER_SECOND(32'd10),
    .SAMPLE_TICKS(32'd100),
    .REFRESH_TICKS(32'd4)
  ) dut (
    .in_clock(clk),
    .in_reset_n(rst_n),
    .in_counter(cnt),
    .in_issue(issue),
    .out_segments(seg),
    .out_digit_enable(en),
    .out_seconds(sec),
    .out_busy(busy)
  );

  countdown_display #(
    .TICKS_PER_SECOND(32'd10),
    .SAMPLE_TICKS(32'd20),
    .REFRESH_TICKS(32'd4)
  ) dut_fast (
    .in_clock(clk),
    .in_reset_n(rst_n),
    .in_counter(cnt2),
    .in_issue(1'b0),
    .out_segments(seg2),
    .out_digit_enable(en2),
    .out_seconds(sec2),
    .out_busy(busy2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // which: 0 = ones, 1 = tens
  task automatic chk_digit(input string tag, input logic which,
                           input logic [6:0] exp);
    logic [1:0] want;
    want = which ? 2'b01 : 2'b10;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (en == want) break;
    end
    chk({tag, "_en"}, {30'd0, en}, {30'd0, want});
    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, exp});
  endtask

  task automatic wait_capture();
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (busy) break;
    end
    chk("capture", {31'd0, busy}, 32'd1);
  endtask

  task automatic conv(input string tag, input logic [31:0] val,
                      input logic [6:0] exp_sec);
    cnt = val;
    wait_capture();
    step(39);
    chk({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
    step(1);
    chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sec"}, {25'd0, sec}, {25'd0, exp_sec});
  endtask

  initial begin
    rst_n = 1'b0;
    cnt   = 32'd350;
    cnt2  = 32'd350;
    issue = 1'b0;
    step(3);
    chk("rst_seg", {25'd0, seg}, {25'd0, BLANK});
    chk("rst_en", {30'd0, en}, 32'd3);
    chk("rst_sec", {25'd0, sec}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // fast instance: capture at edge 20, ticks at 40 and 60 dropped
    step(19);
    chk("fast_idle", {31'd0, busy2}, 32'd0);
    step(1);
    chk("fast_cap", {31'd0, busy2}, 32'd1);
    cnt2 = 32'd990;
    step(39);
    chk("fast_busy39", {31'd0, busy2}, 32'd1);
    step(1);
    chk("fast_done", {31'd0, busy2}, 32'd0);
    chk("fast_sec", {25'd0, sec2}, 32'd35);
    step(19);
    chk("fast_no_requeue", {31'd0, busy2}, 32'd0);

    // main instance: first capture on the 100th edge
    step(20);
    chk("first_idle", {31'd0, busy}, 32'd0);
    step(1);
    chk("first_cap", {31'd0, busy}, 32'd1);
    step(39);
    chk("c350_busy", {31'd0, busy}, 32'd1);
    chk("c350_old_sec", {25'd0, sec}, 32'd0);
    step(1);
    chk("c350_done", {31'd0, busy}, 32'd0);
    chk("c350_sec", {25'd0, sec}, 32'd35);
    chk("fast_sec2", {25'd0, sec2}, 32'd99);
    chk_digit("c350_ones", 1'b0, S5);
    chk_digit("c350_tens", 1'b1, S3);

    conv("c9", 32'd9, 7'd0);
    chk_digit("c9_ones", 1'b0, S0);
    chk_digit("c9_tens", 1'b1, BLANK);
    conv("c10", 32'd10, 7'd1);
    chk_digit("c10_ones", 1'b0, S1);
    chk_digit("c10_tens", 1'b1, BLANK);
    conv("c0", 32'd0, 7'd0);
    chk_digit("c0_ones", 1'b0, S0);
    chk_digit("c0_tens", 1'b1, BLANK);
    conv("cmax", 32'hFFFFFFFF, 7'd99);
    chk_digit("cmax_ones", 1'b0, S9);
    chk_digit("cmax_tens", 1'b1, S9);

    // issue forces dashes while conversion continues
    cnt = 32'd420;
    wait_capture();
    step(5);
    issue = 1'b1;
    step(1);
    chk("iss_dash", {25'd0, seg}, {25'd0, DASH});
    chk_digit("iss_ones", 1'b0, DASH);
    chk_digit("iss_tens", 1'b1, DASH);
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      step(1);
    end
    chk("iss_done", {31'd0, busy}, 32'd0);
    chk("iss_sec", {25'd0, sec}, 32'd42);
    chk("iss_still", {25'd0, seg}, {25'd0, DASH});
    issue = 1'b0;
    step(1);
    chk("iss_release", {25'd0, seg},
        {25'd0, (en == 2'b10) ? S2 : S4});

    // reset during divide aborts conversion
    cnt = 32'd350;
    wait_capture();
    step(20);
    rst_n = 1'b0;
    step(1);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_sec", {25'd0, sec}, 32'd0);
    chk("ar_seg", {25'd0, seg}, {25'd0, BLANK});
    chk("ar_en", {30'd0, en}, 32'd3);
    rst_n = 1'b1;
    step(99);
    chk("ar_idle", {31'd0, busy}, 32'd0);
    step(1);
    chk("ar_cap", {31'd0, busy}, 32'd1);
    step(40);
    chk("ar_sec2", {25'd0, sec}, 32'd35);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/countdown_display.md
COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 The block SHALL expose the following parameters:
  TICKS_PER_SECOND, 32'd50000000, clock ticks per displayed second; must be nonzero.
  SAMPLE_TICKS, 32'd500000, clock cycles between conversions (10 ms).
  REFRESH_TICKS, 32'd50000, clock cycles each digit stays enabled (1 ms).
REQ-002 The block SHALL expose the following ports:
  in_clock  input  1  sole clock; all logic on posedge.
  in_reset_n  input  1  synchronous active-low reset.
  in_counter  input  32  remaining-tick count from the light state machine.
  in_issue  input  1  light in ISSUE state; forces dash display.
  out_segments  output  7  {g,f,e,d,c,b,a}, active-low.
  out_digit_enable  output  2  [0]=ones, [1]=tens, active-low.
  out_seconds  output  7  last converted seconds, binary, 0..99.
  out_busy  output  1  high while a conversion is in progress.

Function
REQ-003 Sample counter SHALL run 0..SAMPLE_TICKS-1 and wrap; sample tick = count equals SAMPLE_TICKS-1.
REQ-004 FSM states SHALL be IDLE, DIVIDE, BCD, LOAD.
REQ-005 IDLE + sample tick: capture in_counter as dividend, go to DIVIDE, out_busy=1 from next cycle.
REQ-006 DIVIDE: restoring shift-subtract, one quotient bit per cycle, exactly 32 cycles, then BCD.
REQ-007 Quotient = floor(captured / TICKS_PER_SECOND); quotient >99 SHALL saturate to 99 before BCD.
REQ-008 BCD: shift-add-3 on 7-bit value, exactly 7 cycles, producing tens and ones digits, then LOAD.
REQ-009 LOAD (1 cycle): update out_seconds and digit registers, clear out_busy, return to IDLE.
REQ-010 Capture edge N -> new out_seconds visible after edge N+40; out_busy high after edges N..N+39.
REQ-011 Sample ticks outside IDLE SHALL be dropped, not queued; sample counter never stalls.
REQ-012 in_counter changes after capture SHALL NOT affect the conversion in progress.
REQ-013 Refresh counter SHALL run 0..REFRESH_TICKS-1; active digit toggles on wrap, ones first after reset.
REQ-014 Only the active digit SHALL have its out_digit_enable bit low.
REQ-015 Patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; dash=0111111; blank=1111111.
REQ-016 Tens digit SHALL be blank when out_seconds <10; ones digit always shown.
REQ-017 in_issue=1 SHALL force dash on the active digit from the next edge, for both digits. Conversions continue and out_seconds still updates.
REQ-018 in_issue falling SHALL restore numeric display from the next edge using current digit registers.
REQ-019 out_segments and out_digit_enable SHALL be registered outputs.

Reset
REQ-020 in_reset_n=0 at an edge SHALL abort any conversion and set:
  FSM=IDLE; sample and refresh counters=0; active digit=ones.
  out_seconds=0; out_busy=0; digit registers=0.
  out_segments=1111111; out_digit_enable=11.
REQ-021 First capture after reset release SHALL occur at the SAMPLE_TICKS-th edge with in_reset_n=1.

Verification
REQ-022 The bench SHALL use TICKS_PER_SECOND=10, SAMPLE_TICKS=100, REFRESH_TICKS=4 and cover:
  in_counter=350 -> out_seconds=35 40 edges after capture; ones shows 5 (0010010), tens shows 3 (0110000).
  in_counter=9, then 10, then 0 -> out_seconds 0, 1, 0; tens blank (1111111) each time.
  in_counter=32'hFFFFFFFF -> out_seconds=99; digits 9/9.
  in_counter changed and extra sample tick mid-conversion -> result reflects the captured value; no second conversion starts until IDLE.
  in_issue=1 during a conversion -> both digits dash next edge; out_seconds still updates at LOAD; release -> numerals return next edge.
  in_reset_n=0 at cycle 20 of DIVIDE -> all REQ-020 values next edge; out_busy=0.
